// File: rtl/mac_seq_mmu.sv
// Sequential NxN matrix unit: loads A and B one packed row per word, computes one result
// element per cycle (add/sub/mul/mac), then streams result rows out under backpressure.
module mac_seq_mmu #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  opcode_i,
  input  logic        clear_acc_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough for acc + sum of N full products, so truncation is the only wrap.
  localparam int unsigned SW = 2 * DW + $clog2(N + 1) + 1;
  localparam logic [CW-1:0] Last = CW'(N - 1);

  if (N * DW > 32) begin : g_width_check
    $error("mac_seq_mmu: N*DW must not exceed 32");
  end

  if (N * DW < 32) begin : g_unused
    logic unused_upper;
    assign unused_upper = ^in_data_i[31:N*DW];
  end

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StStore} state_e;
  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpMac = 2'b11} op_e;

  state_e          state_q, state_d;
  op_e             op_q;
  logic [CW-1:0]   row_q, col_q;
  logic            load_b_q;
  logic            done_q, done_d;
  logic [DW-1:0]   a_q   [N][N];
  logic [DW-1:0]   b_q   [N][N];
  logic [DW-1:0]   res_q [N][N];
  logic [DW-1:0]   acc_q [N][N];

  logic [DW-1:0]   in_row [N];
  logic [SW-1:0]   mul_sum, elem_full;
  logic [DW-1:0]   elem;
  logic [31:0]     out_row;
  logic            in_xfer, out_xfer;

  assign in_ready_o  = (state_q == StLoad);
  assign out_valid_o = (state_q == StStore);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign in_xfer     = in_ready_o && in_valid_i;
  assign out_xfer    = out_valid_o && out_ready_i;

  // Unpack the incoming row word: column 0 sits in the most significant element slot.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      in_row[c] = in_data_i[(N-1-c)*DW +: DW];
    end
  end

  // Result element (row_q, col_q) for the latched opcode, truncated mod 2^DW.
  always_comb begin
    mul_sum = '0;
    for (int k = 0; k < N; k++) begin
      mul_sum = mul_sum + SW'(a_q[row_q][k]) * SW'(b_q[k][col_q]);
    end
    elem_full = '0;
    unique case (op_q)
      OpAdd: elem_full = SW'(a_q[row_q][col_q]) + SW'(b_q[row_q][col_q]);
      OpSub: elem_full = SW'(a_q[row_q][col_q]) - SW'(b_q[row_q][col_q]);
      OpMul: elem_full = mul_sum;
      OpMac: elem_full = SW'(acc_q[row_q][col_q]) + mul_sum;
    endcase
    elem = elem_full[DW-1:0];
  end

  // Pack the current result row; the bus is zero outside STORE.
  always_comb begin
    out_row = '0;
    for (int c = 0; c < N; c++) begin
      out_row[(N-1-c)*DW +: DW] = res_q[row_q][c];
    end
    out_data_o = (state_q == StStore) ? out_row : '0;
  end

  // Next-state and done pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StLoad;
      StLoad:    if (in_xfer && load_b_q && row_q == Last) state_d = StCompute;
      StCompute: if (row_q == Last && col_q == Last) state_d = StStore;
      StStore: begin
        if (out_xfer && row_q == Last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath: operand loading, element computation, accumulator and row/column counters.
  // row_q is shared by the load, compute and store phases; each phase leaves it at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= OpAdd;
      row_q    <= '0;
      col_q    <= '0;
      load_b_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          res_q[i][j] <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      done_q <= done_d;
      unique case (state_q)
        StIdle: begin
          if (clear_acc_i) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
            end
          end
          if (start_i) op_q <= op_e'(opcode_i);
        end
        StLoad: begin
          if (in_xfer) begin
            for (int c = 0; c < N; c++) begin
              if (load_b_q) b_q[row_q][c] <= in_row[c];
              else          a_q[row_q][c] <= in_row[c];
            end
            if (row_q == Last) begin
              row_q    <= '0;
              load_b_q <= ~load_b_q;
            end else begin
              row_q <= row_q + CW'(1);
            end
          end
        end
        StCompute: begin
          res_q[row_q][col_q] <= elem;
          if (op_q == OpMac) acc_q[row_q][col_q] <= elem;
          if (col_q == Last) begin
            col_q <= '0;
            row_q <= (row_q == Last) ? '0 : row_q + CW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        StStore: begin
          if (out_xfer) row_q <= (row_q == Last) ? '0 : row_q + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_mmu.sv
// Self-checking bench for mac_seq_mmu (N=3, DW=8): scoreboard of expected result rows.
module tb_mac_seq_mmu;

  typedef logic [23:0] row_t;

  logic        clk_i, rst_i, start_i, clear_acc_i, in_valid_i, out_ready_i;
  logic [1:0]  opcode_i;
  logic [31:0] in_data_i, out_data_o;
  logic        in_ready_o, out_valid_o, busy_o, done_o;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int unsigned tb_acc [3][3];

  row_t id_a [3];
  row_t mat_b [3];
  row_t ff_a [3];
  row_t two_b [3];
  row_t zero_a [3];
  row_t one_b [3];

  mac_seq_mmu #(.N(3), .DW(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .opcode_i    (opcode_i),
    .clear_acc_i (clear_acc_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int unsigned el(input row_t r, input int c);
    return int'(r[(2-c)*8 +: 8]);
  endfunction

  // Reference model: push the expected rows of one operation, updating the model accumulator.
  task automatic model_push(input logic [1:0] op, input row_t a [3], input row_t b [3]);
    row_t r;
    int unsigned s, m;
    for (int i = 0; i < 3; i++) begin
      r = '0;
      for (int j = 0; j < 3; j++) begin
        m = 0;
        for (int k = 0; k < 3; k++) m += el(a[i], k) * el(b[k], j);
        case (op)
          2'b00:   s = el(a[i], j) + el(b[i], j);
          2'b01:   s = el(a[i], j) - el(b[i], j);
          2'b10:   s = m;
          default: s = tb_acc[i][j] + m;
        endcase
        s = s & 32'hFF;
        if (op == 2'b11) tb_acc[i][j] = s;
        r[(2-j)*8 +: 8] = s[7:0];
      end
      exp_q.push_back({8'h00, r});
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk_i);
    clear_acc_i = 1'b1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) tb_acc[i][j] = 0;
    @(negedge clk_i);
    clear_acc_i = 1'b0;
  endtask

  // Drives one full operation with optional input/output stalls, collecting result words.
  task automatic run_op(input logic [1:0] op, input row_t a [3], input row_t b [3],
                        input bit with_clear, input int in_stall_at, input int in_stall_len,
                        input int out_stall_row, input int out_stall_len,
                        input int busy_start_cyc, output int done_edge, output int dones,
                        output int unstable, output bit timeout);
    int edges, w, n_out, in_rem, out_rem, after;
    bit held;
    logic [31:0] held_data;
    row_t r;
    edges = 0; w = 0; n_out = 0; in_rem = in_stall_len; out_rem = out_stall_len; after = -1;
    held = 1'b0; held_data = '0; done_edge = -1; dones = 0; unstable = 0; timeout = 1'b1;
    @(negedge clk_i);
    if (with_clear) begin
      clear_acc_i = 1'b1;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) tb_acc[i][j] = 0;
    end
    start_i  = 1'b1;
    opcode_i = op;
    model_push(op, a, b);
    @(posedge clk_i);
    edges = 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_i);
      start_i     = (cyc == busy_start_cyc);
      clear_acc_i = start_i;
      opcode_i    = start_i ? 2'b00 : op;
      if (done_o) begin
        dones++;
        if (done_edge < 0) begin
          done_edge = edges;
          after = 3;
        end
      end
      if (after == 0) begin
        timeout = 1'b0;
        break;
      end
      if (after > 0) after--;
      if (held && (!out_valid_o || out_data_o !== held_data)) unstable++;
      if (w == in_stall_at && in_rem > 0) begin
        in_valid_i = 1'b0;
        in_rem--;
      end else begin
        in_valid_i = (w < 6);
      end
      r = (w < 3) ? a[w] : ((w < 6) ? b[w-3] : 24'h5A5A5A);
      in_data_i = {8'hA5, r};
      if (out_valid_o && n_out == out_stall_row && out_rem > 0) begin
        out_ready_i = 1'b0;
        out_rem--;
      end else begin
        out_ready_i = 1'b1;
      end
      held = out_valid_o && !out_ready_i;
      held_data = out_data_o;
      if (in_valid_i && in_ready_o) w++;
      if (out_valid_o && out_ready_i) begin
        obs_q.push_back(out_data_o);
        n_out++;
      end
      @(posedge clk_i);
      edges++;
    end
    if (timeout) @(negedge clk_i);
    start_i = 1'b0; clear_acc_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    @(negedge clk_i);
    got = {27'd0, in_ready_o, out_valid_o, busy_o, done_o, 1'b0};
    tests_run++;
    if (got !== 32'd0) begin
      fails++;
      $display("FAIL reset_flags: got %h required 0", got);
    end
    tests_run++;
    if (out_data_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_out_data: got %h required 0", out_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_mul();
    int de, dn, us; bit to; logic [31:0] got, exp;
    logic [31:0] lit [3];
    lit[0] = 32'h00010203; lit[1] = 32'h00040506; lit[2] = 32'h00070809;
    run_op(2'b10, id_a, mat_b, 1'b0, -1, 0, -1, 0, -1, de, dn, us, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL mul_timeout: no done pulse seen"); end
    tests_run++;
    if (de != 19) begin fails++; $display("FAIL mul_latency: got %0d required 19", de); end
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL mul_done_count: got %0d required 1", dn); end
    for (int r = 0; r < 3; r++) begin
      tests_run++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL mul_row%0d: missing (obs %0d exp %0d)", r, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp || got !== lit[r]) begin
          fails++;
          $display("FAIL mul_row%0d: got %h required %h", r, got, lit[r]);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL mul_extra: got %0d required 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_add_sub_wrap();
    int de, dn, us; bit to; logic [31:0] got, exp;
    run_op(2'b00, ff_a, two_b, 1'b0, -1, 0, -1, 0, -1, de, dn, us, to);
    run_op(2'b01, zero_a, one_b, 1'b0, -1, 0, -1, 0, -1, de, dn, us, to);
    for (int r = 0; r < 6; r++) begin
      tests_run++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL wrap_row%0d: missing (obs %0d exp %0d)", r, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin fails++; $display("FAIL wrap_row%0d: got %h required %h", r, got, exp); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mac();
    int de, dn, us; bit to; logic [31:0] got, exp;
    clear_pulse();
    run_op(2'b11, id_a, mat_b, 1'b0, -1, 0, -1, 0, -1, de, dn, us, to);
    run_op(2'b11, id_a, mat_b, 1'b0, -1, 0, -1, 0, -1, de, dn, us, to);
    run_op(2'b11, id_a, mat_b, 1'b1, -1, 0, -1, 0, -1, de, dn, us, to);
    for (int r = 0; r < 9; r++) begin
      tests_run++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL mac_row%0d: missing (obs %0d exp %0d)", r, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin fails++; $display("FAIL mac_row%0d: got %h required %h", r, got, exp); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int de, dn, us; bit to; logic [31:0] got, exp;
    run_op(2'b10, id_a, mat_b, 1'b0, 2, 5, 1, 4, -1, de, dn, us, to);
    tests_run++;
    if (us != 0) begin fails++; $display("FAIL bp_stable: got %0d changes required 0", us); end
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL bp_done_count: got %0d required 1", dn); end
    tests_run++;
    if (de != 28) begin fails++; $display("FAIL bp_latency: got %0d required 28", de); end
    for (int r = 0; r < 3; r++) begin
      tests_run++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL bp_row%0d: missing (obs %0d exp %0d)", r, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin fails++; $display("FAIL bp_row%0d: got %h required %h", r, got, exp); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_compute();
    int de, dn, us; bit to; logic [31:0] got, exp, flags;
    @(negedge clk_i);
    start_i = 1'b1; opcode_i = 2'b10;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int w = 0; w < 6; w++) begin
      in_valid_i = 1'b1;
      in_data_i  = {8'h00, (w < 3) ? ff_a[w] : two_b[w-3]};
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    tests_run++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b required 1", busy_o); end
    #2 rst_i = 1'b1;
    #1;
    flags = {27'd0, in_ready_o, out_valid_o, busy_o, done_o, 1'b0};
    tests_run++;
    if (flags !== 32'd0 || out_data_o !== 32'd0) begin
      fails++;
      $display("FAIL midrst_outputs: got flags %h data %h required 0", flags, out_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(2'b10, id_a, mat_b, 1'b0, -1, 0, -1, 0, 10, de, dn, us, to);
    tests_run++;
    if (obs_q.size() != 3) begin fails++; $display("FAIL midrst_count: got %0d required 3", obs_q.size()); end
    for (int r = 0; r < 3; r++) begin
      tests_run++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL midrst_row%0d: missing (obs %0d exp %0d)", r, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin fails++; $display("FAIL midrst_row%0d: got %h required %h", r, got, exp); end
      end
    end
    tests_run++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL busy_start_ignored: got %b required 0", busy_o); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    id_a[0]   = 24'h010000; id_a[1]   = 24'h000100; id_a[2]   = 24'h000001;
    mat_b[0]  = 24'h010203; mat_b[1]  = 24'h040506; mat_b[2]  = 24'h070809;
    for (int i = 0; i < 3; i++) begin
      ff_a[i] = 24'hFFFFFF; two_b[i] = 24'h020202; zero_a[i] = 24'h000000; one_b[i] = 24'h010101;
      for (int j = 0; j < 3; j++) tb_acc[i][j] = 0;
    end
    rst_i = 1'b1; start_i = 1'b0; opcode_i = 2'b00; clear_acc_i = 1'b0;
    in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    test_reset();
    test_mul();
    test_add_sub_wrap();
    test_mac();
    test_backpressure();
    test_reset_mid_compute();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mac_seq_mmu.md
Name: mac_seq_mmu

Overview:
- Parametrised, sequential successor to the combinational 3x3 matrix unit.
- Streams two NxN matrices in one packed row per 32-bit word, computes one result element per cycle, then streams the result rows out.
- Adds valid/ready handshakes, a persistent accumulator (MAC mode), busy/done status and output backpressure.
- Sits between the core's load/store path and data memory.

Parameters:
N, 3, matrix dimension; elements per row word.
DW, 8, element width in bits; N*DW must be <= 32 (elaboration error otherwise).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  begin operation; sampled only in IDLE.
opcode_i  in  2  00 add, 01 sub, 10 multiply, 11 multiply-accumulate; latched on accepted start.
clear_acc_i  in  1  clears accumulator matrix; honoured only in IDLE.
in_data_i  in  32  packed row word from memory.
in_valid_i  in  1  in_data_i valid.
in_ready_o  out  1  unit accepts a row word.
out_data_o  out  32  packed result row word to memory.
out_valid_o  out  1  out_data_o valid.
out_ready_i  in  1  memory accepts the result word.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse after the last result word transfers.

Behaviour:
- Packing: element column 0 in bits [N*DW-1 -: DW], column N-1 in bits [DW-1:0]. Bits [31:N*DW] are ignored on input and zero on output. Rows are transferred row 0 first.
- Reset: state IDLE; all A, B, result and accumulator storage cleared to 0; all counters 0. in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0.
- Reset mid-operation aborts immediately with the same values. No partial result is emitted.
- IDLE:
  - start_i=1 latches opcode and goes to LOAD next cycle.
  - clear_acc_i=1 zeros the accumulator in one cycle.
  - If both are high in the same cycle, the clear takes effect first; the started operation sees a zero accumulator.
- LOAD:
  - in_ready_o=1. A word transfers when in_valid_i && in_ready_o.
  - Words 0..N-1 fill rows of A; words N..2N-1 fill rows of B.
  - in_valid_i low stalls the load without limit.
  - After word 2N-1 transfers, go to COMPUTE; in_ready_o drops in that cycle's next state.
- COMPUTE:
  - Exactly N*N cycles, element (i,j) in raster order, one per cycle.
  - add: A[i][j]+B[i][j]. sub: A[i][j]-B[i][j].
  - mul: sum over k of A[i][k]*B[k][j].
  - mac: ACC[i][j] + sum over k of A[i][k]*B[k][j]; the result is also written back to ACC[i][j].
  - All arithmetic is unsigned, computed at full width, then truncated mod 2^DW (wrap, no saturation).
  - add, sub and mul do not modify ACC.
  - Then go to STORE.
- STORE:
  - out_valid_o=1 with out_data_o = packed result row r, r=0..N-1.
  - Row r is held stable while out_ready_i=0.
  - r advances on out_valid_o && out_ready_i.
  - After row N-1 transfers: done_o=1 for one cycle, return to IDLE with out_valid_o=0.
- start_i while busy is ignored. in_valid_i outside LOAD is ignored.
- Total latency with no stalls: 1 (start) + 2N (load) + N*N (compute) + N (store) cycles. For N=3 this is 1+6+9+3 = 19 cycles, then the done pulse.

Test Plan:
- N=3, DW=8, mul: A rows 0x010000, 0x000100, 0x000001; B rows 0x010203, 0x040506, 0x070809 -> out rows 0x010203, 0x040506, 0x070809; done pulse at cycle 19 after start; upper byte of out_data_o 0x00.
- add wrap: A all rows 0xFFFFFF, B all rows 0x020202 -> every out row 0x010101.
- sub wrap: A all rows 0x000000, B all rows 0x010101 -> every out row 0xFFFFFF.
- mac: clear_acc_i pulse, then two mac ops with the identity A and B above -> second op outputs 0x020406, 0x080A0C, 0x0E1012. A following clear_acc_i plus mac outputs B unchanged.
- Backpressure and stall:
  - Deassert in_valid_i for 5 cycles mid-LOAD -> no words lost.
  - Hold out_ready_i=0 for 4 cycles on row 1 -> out_data_o stable, out_valid_o held high, rows in order, one done pulse.
- Reset mid-COMPUTE:
  - Assert rst_i asynchronously -> all outputs 0, busy_o=0.
  - The next mul op returns correct results with no stale row.
  - start_i pulsed while busy has no effect.
